// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - opcode/funct, select codes, ALU ops, states and instruction classes for mc_ctrl_fsm
package mc_ctrl_pkg;

  // Primary opcodes (Instr[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type function codes (Instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  // ALUControl encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;

  // Datapath mux select codes
  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JMP  = 2'b10;
  localparam logic [1:0] PCSRC_REG  = 2'b11;
  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_RA  = 2'b10;
  localparam logic [1:0] WDSEL_ALU  = 2'b00;
  localparam logic [1:0] WDSEL_MDR  = 2'b01;
  localparam logic [1:0] WDSEL_PC   = 2'b10;
  localparam logic [1:0] EXT_ZERO   = 2'b00;
  localparam logic [1:0] EXT_SIGN   = 2'b01;
  localparam logic [1:0] EXT_HIGH   = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Bit positions of the one-hot instruction class vector
  localparam int C_RALU    = 0;
  localparam int C_ORI     = 1;
  localparam int C_LUI     = 2;
  localparam int C_LW      = 3;
  localparam int C_SW      = 4;
  localparam int C_BEQ     = 5;
  localparam int C_BGTZ    = 6;
  localparam int C_BLTZ    = 7;
  localparam int C_J       = 8;
  localparam int C_JAL     = 9;
  localparam int C_JR      = 10;
  localparam int C_UNKNOWN = 11;
  localparam int CLS_W     = 12;

  typedef logic [CLS_W-1:0] iclass_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - control bus between mc_ctrl_fsm (master) and the multi-cycle datapath (slave)
interface mc_ctrl_if #(parameter int ALUCTRL_W = 3);
  logic [31:0]          Instr;
  logic                 Zero;
  logic                 GreatZero;
  logic                 LessZero;
  logic                 IRWrite;
  logic                 PCWrite;
  logic [1:0]           PCSrc;
  logic                 RegWrite;
  logic [1:0]           RegDst;
  logic [1:0]           WDSel;
  logic                 ALUSrcA;
  logic                 ALUSrcB;
  logic [1:0]           ExtOp;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 MemWrite;
  logic                 Retire;
  logic                 Illegal;
  logic [2:0]           State;

  modport master (
    input  Instr, Zero, GreatZero, LessZero,
    output IRWrite, PCWrite, PCSrc, RegWrite, RegDst, WDSel, ALUSrcA, ALUSrcB,
           ExtOp, ALUControl, MemWrite, Retire, Illegal, State
  );

  modport slave (
    output Instr, Zero, GreatZero, LessZero,
    input  IRWrite, PCWrite, PCSrc, RegWrite, RegDst, WDSel, ALUSrcA, ALUSrcB,
           ExtOp, ALUControl, MemWrite, Retire, Illegal, State
  );
endinterface

// File: rtl/mc_instr_decode.sv
// rtl/mc_instr_decode.sv - instruction fields -> one-hot class plus ALU op for R-type arithmetic
module mc_instr_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [4:0] i_rt,
  input  logic [5:0] i_funct,
  output iclass_t    o_class,
  output logic [2:0] o_ralu_op
);

  // Classify opcode/funct; anything not recognised lands in UNKNOWN
  always_comb begin
    o_class   = '0;
    o_ralu_op = ALU_ADD;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADDU: o_class[C_RALU] = 1'b1;
          FN_SUBU: begin
            o_class[C_RALU] = 1'b1;
            o_ralu_op       = ALU_SUB;
          end
          FN_SLL: begin
            o_class[C_RALU] = 1'b1;
            o_ralu_op       = ALU_SLL;
          end
          FN_JR:   o_class[C_JR] = 1'b1;
          default: o_class[C_UNKNOWN] = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        if (i_rt == 5'd0) o_class[C_BLTZ] = 1'b1;
        else              o_class[C_UNKNOWN] = 1'b1;
      end
      OP_J:    o_class[C_J]    = 1'b1;
      OP_JAL:  o_class[C_JAL]  = 1'b1;
      OP_BEQ:  o_class[C_BEQ]  = 1'b1;
      OP_BGTZ: o_class[C_BGTZ] = 1'b1;
      OP_ORI:  o_class[C_ORI]  = 1'b1;
      OP_LUI:  o_class[C_LUI]  = 1'b1;
      OP_LW:   o_class[C_LW]   = 1'b1;
      OP_SW:   o_class[C_SW]   = 1'b1;
      default: o_class[C_UNKNOWN] = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS control FSM; MC_ILLEGAL_TRAP_EN traps unknown instructions into HALT
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master dp
);

  state_t     r_state;
  state_t     w_next;
  iclass_t    w_class;
  logic [2:0] w_ralu_op;
  logic       w_irw, w_pcw, w_rw, w_mw, w_ret, w_sa, w_sb;
  logic [1:0] w_pcsrc, w_regdst, w_wdsel, w_ext;
  logic [2:0] w_alu;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       r_illegal;
  logic       w_trap;
`endif

  mc_instr_decode u_dec (
    .i_op      (dp.Instr[31:26]),
    .i_rt      (dp.Instr[20:16]),
    .i_funct   (dp.Instr[5:0]),
    .o_class   (w_class),
    .o_ralu_op (w_ralu_op)
  );

  // Next state and per-state datapath controls; unlisted controls stay 0
  always_comb begin
    w_next   = r_state;
    w_irw    = 1'b0;
    w_pcw    = 1'b0;
    w_rw     = 1'b0;
    w_mw     = 1'b0;
    w_ret    = 1'b0;
    w_sa     = 1'b0;
    w_sb     = 1'b0;
    w_pcsrc  = PCSRC_SEQ;
    w_regdst = REGDST_RT;
    w_wdsel  = WDSEL_ALU;
    w_ext    = EXT_ZERO;
    w_alu    = ALU_ADD;
`ifdef MC_ILLEGAL_TRAP_EN
    w_trap   = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        w_irw  = 1'b1;
        w_pcw  = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_class[C_J] || w_class[C_JAL]) begin
          w_pcw   = 1'b1;
          w_pcsrc = PCSRC_JMP;
          w_ret   = 1'b1;
          w_next  = S_FETCH;
          if (w_class[C_JAL]) begin
            w_rw     = 1'b1;
            w_regdst = REGDST_RA;
            w_wdsel  = WDSEL_PC;
          end
        end else if (w_class[C_JR]) begin
          w_pcw   = 1'b1;
          w_pcsrc = PCSRC_REG;
          w_ret   = 1'b1;
          w_next  = S_FETCH;
        end else if (w_class[C_UNKNOWN]) begin
`ifdef MC_ILLEGAL_TRAP_EN
          w_trap = 1'b1;
          w_next = S_HALT;
`else
          w_ret  = 1'b1;
          w_next = S_FETCH;
`endif
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_class[C_RALU]) begin
          w_alu  = w_ralu_op;
          w_next = S_WB;
        end else if (w_class[C_ORI] || w_class[C_LUI]) begin
          w_sa   = w_class[C_LUI];
          w_ext  = w_class[C_LUI] ? EXT_HIGH : EXT_ZERO;
          w_sb   = 1'b1;
          w_alu  = ALU_OR;
          w_next = S_WB;
        end else if (w_class[C_LW] || w_class[C_SW]) begin
          w_ext  = EXT_SIGN;
          w_sb   = 1'b1;
          w_next = S_MEM;
        end else begin
          // Branches: PC already holds PC+4, so the branch target is relative to it
          w_pcsrc = PCSRC_BR;
          w_ret   = 1'b1;
          w_next  = S_FETCH;
          if (w_class[C_BEQ]) begin
            w_alu = ALU_SUB;
            w_pcw = dp.Zero;
          end else if (w_class[C_BGTZ]) begin
            w_pcw = dp.GreatZero;
          end else if (w_class[C_BLTZ]) begin
            w_pcw = dp.LessZero;
          end
        end
      end
      S_MEM: begin
        if (w_class[C_SW]) begin
          w_mw   = 1'b1;
          w_ret  = 1'b1;
          w_next = S_FETCH;
        end else begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        w_rw     = 1'b1;
        w_ret    = 1'b1;
        w_regdst = w_class[C_RALU] ? REGDST_RD : REGDST_RT;
        w_wdsel  = w_class[C_LW] ? WDSEL_MDR : WDSEL_ALU;
        w_next   = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
    // A reset cycle must not let any write or retire complete
    if (reset) begin
      w_irw = 1'b0;
      w_pcw = 1'b0;
      w_rw  = 1'b0;
      w_mw  = 1'b0;
      w_ret = 1'b0;
    end
  end

  // State register and sticky illegal flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      r_state   <= w_next;
`ifdef MC_ILLEGAL_TRAP_EN
      if (w_trap) r_illegal <= 1'b1;
`endif
    end
  end

  assign dp.IRWrite    = w_irw;
  assign dp.PCWrite    = w_pcw;
  assign dp.PCSrc      = w_pcsrc;
  assign dp.RegWrite   = w_rw;
  assign dp.RegDst     = w_regdst;
  assign dp.WDSel      = w_wdsel;
  assign dp.ALUSrcA    = w_sa;
  assign dp.ALUSrcB    = w_sb;
  assign dp.ExtOp      = w_ext;
  assign dp.ALUControl = ALUCTRL_W'(w_alu);
  assign dp.MemWrite   = w_mw;
  assign dp.Retire     = w_ret;
  assign dp.State      = r_state;
`ifdef MC_ILLEGAL_TRAP_EN
  assign dp.Illegal    = r_illegal;
`else
  assign dp.Illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [20:0] v_fetch, v_decode, v_wb_rt;

  mc_ctrl_if #(.ALUCTRL_W(3)) bus ();
  mc_ctrl_fsm #(.ALUCTRL_W(3)) dut (.clk(clk), .reset(reset), .dp(bus));

  always #5 clk = ~clk;

  function automatic logic [20:0] mk(input logic [2:0] st, input logic irw, input logic pcw,
                                     input logic [1:0] pcsrc, input logic rw, input logic [1:0] rdst,
                                     input logic [1:0] wd, input logic sa, input logic sb,
                                     input logic [1:0] ext, input logic [2:0] alu, input logic mw,
                                     input logic ret);
    return {st, irw, pcw, pcsrc, rw, rdst, wd, sa, sb, ext, alu, mw, ret};
  endfunction

  function automatic logic [20:0] obs();
    return {bus.State, bus.IRWrite, bus.PCWrite, bus.PCSrc, bus.RegWrite, bus.RegDst, bus.WDSel,
            bus.ALUSrcA, bus.ALUSrcB, bus.ExtOp, bus.ALUControl, bus.MemWrite, bus.Retire};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] ins, input logic z, input logic g, input logic l);
    bus.Instr     = ins;
    bus.Zero      = z;
    bus.GreatZero = g;
    bus.LessZero  = l;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(32'h0000_0000, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    #1;
    total++;
    if (bus.State !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", bus.State); end
    total++;
    if ({bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite} !== 4'b0000) begin
      bad++; $display("FAIL reset_enables: got %b want 0000", {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite});
    end
    total++;
    if (bus.Illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %b want 0", bus.Illegal); end
    reset = 1'b0;
  endtask

  task automatic test_r_type();
    logic [31:0] ins [3];
    logic [2:0]  op  [3];
    logic [20:0] exp [4];
    ins = '{32'h0022_1821, 32'h0022_1823, 32'h0002_1900};
    op  = '{3'd0, 3'd1, 3'd4};
    for (int i = 0; i < 3; i++) begin
      set_in(ins[i], 1'b0, 1'b0, 1'b0);
      exp = '{v_fetch, v_decode,
              mk(3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, op[i], 1'b0, 1'b0),
              mk(3'd4, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1)};
      for (int c = 0; c < 4; c++) begin
        #1;
        total++;
        if (obs() !== exp[c]) begin bad++; $display("FAIL r_type[%0d] cyc%0d: got %h want %h", i, c, obs(), exp[c]); end
        tick();
      end
    end
  endtask

  task automatic test_imm();
    logic [31:0] ins [2];
    logic [20:0] ex  [2];
    logic [20:0] exp [4];
    ins = '{32'h3422_1234, 32'h3C02_1234};
    ex  = '{mk(3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 3'd3, 1'b0, 1'b0),
            mk(3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 3'd3, 1'b0, 1'b0)};
    for (int i = 0; i < 2; i++) begin
      set_in(ins[i], 1'b0, 1'b0, 1'b0);
      exp = '{v_fetch, v_decode, ex[i], v_wb_rt};
      for (int c = 0; c < 4; c++) begin
        #1;
        total++;
        if (obs() !== exp[c]) begin bad++; $display("FAIL imm[%0d] cyc%0d: got %h want %h", i, c, obs(), exp[c]); end
        tick();
      end
    end
  endtask

  task automatic test_mem();
    logic [20:0] ex;
    logic [20:0] exp [5];
    ex = mk(3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01, 3'd0, 1'b0, 1'b0);
    set_in(32'h8C85_0008, 1'b0, 1'b0, 1'b0);
    exp = '{v_fetch, v_decode, ex,
            mk(3'd3, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0),
            mk(3'd4, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1)};
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (obs() !== exp[c]) begin bad++; $display("FAIL lw cyc%0d: got %h want %h", c, obs(), exp[c]); end
      tick();
    end
    set_in(32'hAC85_0008, 1'b0, 1'b0, 1'b0);
    exp[3] = mk(3'd3, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd0, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (obs() !== exp[c]) begin bad++; $display("FAIL sw cyc%0d: got %h want %h", c, obs(), exp[c]); end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins [5];
    logic [2:0]  fl  [5];
    logic [20:0] ex  [5];
    logic [20:0] exp [3];
    ins = '{32'h1022_0004, 32'h1022_0004, 32'h1C20_0004, 32'h0420_0004, 32'h0420_0004};
    fl  = '{3'b100, 3'b011, 3'b010, 3'b110, 3'b001};
    ex  = '{mk(3'd2, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd1, 1'b0, 1'b1),
            mk(3'd2, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd1, 1'b0, 1'b1),
            mk(3'd2, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1),
            mk(3'd2, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1),
            mk(3'd2, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1)};
    for (int i = 0; i < 5; i++) begin
      set_in(ins[i], fl[i][2], fl[i][1], fl[i][0]);
      exp = '{v_fetch, v_decode, ex[i]};
      for (int c = 0; c < 3; c++) begin
        #1;
        total++;
        if (obs() !== exp[c]) begin bad++; $display("FAIL branch[%0d] cyc%0d: got %h want %h", i, c, obs(), exp[c]); end
        tick();
      end
    end
  endtask

  task automatic test_jump();
    logic [31:0] ins [3];
    logic [20:0] ex  [3];
    logic [20:0] exp [2];
    ins = '{32'h0C10_0004, 32'h0810_0004, 32'h03E0_0008};
    ex  = '{mk(3'd1, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1),
            mk(3'd1, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1),
            mk(3'd1, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1)};
    for (int i = 0; i < 3; i++) begin
      set_in(ins[i], 1'b1, 1'b1, 1'b1);
      exp = '{v_fetch, ex[i]};
      for (int c = 0; c < 2; c++) begin
        #1;
        total++;
        if (obs() !== exp[c]) begin bad++; $display("FAIL jump[%0d] cyc%0d: got %h want %h", i, c, obs(), exp[c]); end
        tick();
      end
    end
  endtask

  task automatic test_illegal();
    logic [20:0] exp [2];
    set_in(32'hFC00_0000, 1'b0, 1'b0, 1'b0);
`ifdef MC_ILLEGAL_TRAP_EN
    exp = '{v_fetch, v_decode};
`else
    exp = '{v_fetch, mk(3'd1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1)};
`endif
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (obs() !== exp[c]) begin bad++; $display("FAIL illegal cyc%0d: got %h want %h", c, obs(), exp[c]); end
      tick();
    end
`ifdef MC_ILLEGAL_TRAP_EN
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if ({bus.Illegal, obs()} !== {1'b1, mk(3'd5, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0)}) begin
        bad++; $display("FAIL halt cyc%0d: got %h want %h", c, {bus.Illegal, obs()}, {1'b1, 21'h140000});
      end
      tick();
    end
    reset = 1'b1;
    tick();
    total++;
    if ({bus.Illegal, bus.State} !== 4'b0000) begin bad++; $display("FAIL halt_reset: got %b want 0000", {bus.Illegal, bus.State}); end
    reset = 1'b0;
`else
    #1;
    total++;
    if ({bus.Illegal, bus.State} !== 4'b0000) begin bad++; $display("FAIL illegal_nop: got %b want 0000", {bus.Illegal, bus.State}); end
`endif
  endtask

  task automatic test_reset_in_mem();
    set_in(32'hAC85_0008, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    total++;
    if ({bus.State, bus.MemWrite} !== {3'd3, 1'b0}) begin
      bad++; $display("FAIL reset_mem: got state=%0d memwrite=%b want state=3 memwrite=0", bus.State, bus.MemWrite);
    end
    tick();
    total++;
    if ({bus.Illegal, bus.State} !== 4'b0000) begin bad++; $display("FAIL reset_mem_next: got %b want 0000", {bus.Illegal, bus.State}); end
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    v_fetch  = mk(3'd0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
    v_decode = mk(3'd1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
    v_wb_rt  = mk(3'd4, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1);
    test_reset();
    test_r_type();
    test_imm();
    test_mem();
    test_branch();
    test_jump();
    test_illegal();
    test_reset_in_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
